// File: rtl/riscv_bus_arb_if.sv
// rtl/riscv_bus_arb_if.sv - master-side and slave-side bus signals of riscv_bus_arb
//
// Parameters: XLEN (address/data width), NMASTERS (2..4).
// m_* fields are packed per master: master i at [i*XLEN +: XLEN] or [i*XLEN/8 +: XLEN/8].
// Modports:
//   master : view of the bus masters plus slave read data source (drives requests, s_rdata)
//   slave  : view of the arbiter (consumes requests and s_rdata, drives grants and s_*)
interface riscv_bus_arb_if #(
  parameter int XLEN     = 32,
  parameter int NMASTERS = 2
);
  logic [NMASTERS-1:0]          m_req;
  logic [NMASTERS-1:0]          m_we;
  logic [NMASTERS*XLEN/8-1:0]   m_be;
  logic [NMASTERS*XLEN-1:0]     m_addr;
  logic [NMASTERS*XLEN-1:0]     m_wdata;
  logic [NMASTERS-1:0]          m_lock;
  logic [NMASTERS-1:0]          m_gnt;
  logic [NMASTERS-1:0]          m_rvalid;
  logic [XLEN-1:0]              m_rdata;
  logic                         s_req;
  logic                         s_we;
  logic [XLEN/8-1:0]            s_be;
  logic [XLEN-1:0]              s_addr;
  logic [XLEN-1:0]              s_wdata;
  logic [XLEN-1:0]              s_rdata;

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata, m_lock, s_rdata,
    input  m_gnt, m_rvalid, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata, m_lock, s_rdata,
    output m_gnt, m_rvalid, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );
endinterface

// File: rtl/riscv_bus_arb.sv
// rtl/riscv_bus_arb.sv - burst-limited round-robin arbiter for the shared SoC data bus
//
// Parameters: XLEN (address/data width), NMASTERS (2..4), MAXBURST (consecutive grants
// to one master while another requests; 1 = pure round-robin).
// Optional feature macro: ARB_LOCK_EN (honor m_lock; otherwise m_lock is ignored).
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - riscv_bus_arb_if.slave: m_req/m_we/m_be/m_addr/m_wdata/m_lock in,
//          m_gnt/m_rvalid/m_rdata out, s_req/s_we/s_be/s_addr/s_wdata out, s_rdata in
module riscv_bus_arb #(
  parameter int XLEN     = 32,
  parameter int NMASTERS = 2,
  parameter int MAXBURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_bus_arb_if.slave        bus
);
  localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int CW = $clog2(MAXBURST + 1);
  localparam int BW = XLEN / 8;
  localparam logic [CW-1:0] MAXB = CW'(MAXBURST);

  logic [IW-1:0] last;
  logic [CW-1:0] burst_cnt;
  logic          r_pend;
  logic [IW-1:0] r_owner;

  logic          others_req;
  logic          keep_last;
  logic          found;
  logic          grant;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;

  // Winner selection. A zero burst_cnt means the previous tenure ended (reset or an
  // idle cycle), so the last owner gets no preference and the scan starts at last+1;
  // this is what lets master 0 win first out of reset with last = NMASTERS-1.
  always_comb begin
    others_req = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (IW'(i) != last && bus.m_req[i]) others_req = 1'b1;
    end
    keep_last = bus.m_req[last] &&
                ((burst_cnt != '0 && burst_cnt < MAXB) || !others_req);
`ifdef ARB_LOCK_EN
    if (bus.m_req[last] && bus.m_lock[last]) keep_last = 1'b1;
`endif
    found = keep_last;
    win   = last;
    cand  = last;
    // k runs up to NMASTERS so a sole requester that is also last is still found.
    for (int k = 1; k <= NMASTERS; k++) begin
      cand = IW'((int'(last) + k) % NMASTERS);
      if (!found && bus.m_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = found && !rst;
  end

`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^bus.m_lock;
`endif

  // Slave-side routing; with no winner the address/data mux rests on master 0.
  always_comb begin
    bus.m_gnt   = '0;
    bus.s_req   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_be    = '0;
    bus.s_addr  = bus.m_addr[XLEN-1:0];
    bus.s_wdata = bus.m_wdata[XLEN-1:0];
    if (grant) begin
      bus.m_gnt[win] = 1'b1;
      bus.s_req      = 1'b1;
      bus.s_we       = bus.m_we[win];
      bus.s_be       = bus.m_be[win*BW +: BW];
      bus.s_addr     = bus.m_addr[win*XLEN +: XLEN];
      bus.s_wdata    = bus.m_wdata[win*XLEN +: XLEN];
    end
  end

  always_comb begin
    bus.m_rvalid = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      bus.m_rvalid[i] = r_pend && !rst && (r_owner == IW'(i));
    end
  end

  assign bus.m_rdata = bus.s_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= IW'(NMASTERS - 1);
      burst_cnt <= '0;
      r_pend    <= 1'b0;
      r_owner   <= '0;
    end else if (grant) begin
      last    <= win;
      r_pend  <= ~bus.m_we[win];
      r_owner <= win;
      if (win == last) begin
        burst_cnt <= (burst_cnt == MAXB) ? MAXB : burst_cnt + CW'(1);
      end else begin
        burst_cnt <= CW'(1);
      end
    end else begin
      // Any request always produces a winner, so no grant means the bus was idle.
      r_pend    <= 1'b0;
      burst_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_riscv_bus_arb.sv
// tb/tb_riscv_bus_arb.sv - directed self-checking bench for riscv_bus_arb
module tb_riscv_bus_arb;
  logic clk;
  logic rst;
  logic rst_b;
  int   checks;
  int   errors;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;

  riscv_bus_arb_if #(.XLEN(32), .NMASTERS(2)) bus_a ();
  riscv_bus_arb_if #(.XLEN(32), .NMASTERS(2)) bus_b ();

  riscv_bus_arb #(.XLEN(32), .NMASTERS(2), .MAXBURST(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  riscv_bus_arb #(.XLEN(32), .NMASTERS(2), .MAXBURST(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_a.m_req = 2'b11;
    tick();
    #1;
    checks++;
    if (bus_a.m_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", bus_a.m_gnt); end
    checks++;
    if (bus_a.s_req !== 1'b0) begin errors++; $display("FAIL reset_sreq got %b exp 0", bus_a.s_req); end
    checks++;
    if (bus_a.m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", bus_a.m_rvalid); end
    tick();
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    logic [1:0] prev;
    prev = 2'b00;
    rst = 1'b0;
    bus_a.m_req = 2'b11;
    bus_a.m_we = 2'b00;
    bus_a.m_be = 8'hFF;
    bus_a.m_addr = {A1, A0};
    for (int i = 0; i < 10; i++) begin
      bus_a.s_rdata = 32'hC0DE_0000 + 32'(i);
      #1;
      checks++;
      if (bus_a.m_gnt !== exp_g[i]) begin
        errors++; $display("FAIL rr_gnt cyc %0d got %b exp %b", i, bus_a.m_gnt, exp_g[i]);
      end
      checks++;
      if (bus_a.s_addr !== ((exp_g[i] == 2'b01) ? A0 : A1) || bus_a.s_req !== 1'b1 || bus_a.s_we !== 1'b0) begin
        errors++; $display("FAIL rr_slave cyc %0d got addr %h req %b we %b", i, bus_a.s_addr, bus_a.s_req, bus_a.s_we);
      end
      checks++;
      if (bus_a.m_rvalid !== prev) begin
        errors++; $display("FAIL rr_rvalid cyc %0d got %b exp %b", i, bus_a.m_rvalid, prev);
      end
      checks++;
      if (bus_a.m_rdata !== 32'hC0DE_0000 + 32'(i)) begin
        errors++; $display("FAIL rr_rdata cyc %0d got %h exp %h", i, bus_a.m_rdata, 32'hC0DE_0000 + 32'(i));
      end
      prev = exp_g[i];
      tick();
    end
  endtask

  task automatic test_max_burst_one;
    logic [1:0] exp_g;
    rst_b = 1'b1;
    bus_b.m_req = 2'b11;
    tick();
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (bus_b.m_gnt !== exp_g) begin
        errors++; $display("FAIL mb1_gnt cyc %0d got %b exp %b", i, bus_b.m_gnt, exp_g);
      end
      checks++;
      if (dut_b.burst_cnt !== ((i == 0) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL mb1_burst cyc %0d got %0d exp %0d", i, dut_b.burst_cnt, (i == 0) ? 0 : 1);
      end
      tick();
    end
    bus_b.m_req = 2'b00;
  endtask

  task automatic test_sole_requester;
    bus_a.m_req = 2'b00;
    #1;
    checks++;
    if (bus_a.s_req !== 1'b0 || bus_a.m_gnt !== 2'b00) begin
      errors++; $display("FAIL idle got req %b gnt %b exp 0 00", bus_a.s_req, bus_a.m_gnt);
    end
    tick();
    bus_a.m_req = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus_a.m_gnt !== 2'b10) begin
        errors++; $display("FAIL sole_gnt cyc %0d got %b exp 10", i, bus_a.m_gnt);
      end
      tick();
    end
    bus_a.m_req = 2'b11;
    #1;
    checks++;
    if (bus_a.m_gnt !== 2'b01) begin
      errors++; $display("FAIL sole_join got %b exp 01", bus_a.m_gnt);
    end
    tick();
    bus_a.m_req = 2'b00;
    tick();
  endtask

  task automatic test_write;
    bus_a.m_req = 2'b01;
    bus_a.m_we = 2'b01;
    bus_a.m_be = {4'h0, 4'b0011};
    bus_a.m_addr = {A1, 32'h0000_0010};
    bus_a.m_wdata = {32'h1111_2222, 32'hDEAD_BEEF};
    #1;
    checks++;
    if (bus_a.m_gnt !== 2'b01 || bus_a.s_req !== 1'b1 || bus_a.s_we !== 1'b1) begin
      errors++; $display("FAIL wr_ctl got gnt %b req %b we %b exp 01 1 1", bus_a.m_gnt, bus_a.s_req, bus_a.s_we);
    end
    checks++;
    if (bus_a.s_be !== 4'b0011 || bus_a.s_addr !== 32'h10 || bus_a.s_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_fields got be %b addr %h wdata %h", bus_a.s_be, bus_a.s_addr, bus_a.s_wdata);
    end
    tick();
    bus_a.m_req = 2'b00;
    #1;
    checks++;
    if (bus_a.m_rvalid !== 2'b00) begin
      errors++; $display("FAIL wr_no_rvalid got %b exp 00", bus_a.m_rvalid);
    end
    checks++;
    if (bus_a.s_we !== 1'b0 || bus_a.s_be !== 4'b0000 || bus_a.s_addr !== 32'h10) begin
      errors++; $display("FAIL idle_fields got we %b be %b addr %h", bus_a.s_we, bus_a.s_be, bus_a.s_addr);
    end
    bus_a.m_we = 2'b00;
    bus_a.m_addr = {A1, A0};
    tick();
  endtask

  task automatic test_reset_mid_read;
    bus_a.m_req = 2'b10;
    #1;
    checks++;
    if (bus_a.m_gnt !== 2'b10) begin
      errors++; $display("FAIL rmr_gnt got %b exp 10", bus_a.m_gnt);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.m_rvalid !== 2'b00 || bus_a.m_gnt !== 2'b00) begin
      errors++; $display("FAIL rmr_in_reset got rvalid %b gnt %b exp 00 00", bus_a.m_rvalid, bus_a.m_gnt);
    end
    tick();
    rst = 1'b0;
    bus_a.m_req = 2'b11;
    #1;
    checks++;
    if (bus_a.m_rvalid !== 2'b00) begin
      errors++; $display("FAIL rmr_dropped got %b exp 00", bus_a.m_rvalid);
    end
    checks++;
    if (bus_a.m_gnt !== 2'b01) begin
      errors++; $display("FAIL rmr_first_gnt got %b exp 01", bus_a.m_gnt);
    end
    tick();
    bus_a.m_req = 2'b00;
    #1;
    checks++;
    if (bus_a.m_rvalid !== 2'b01) begin
      errors++; $display("FAIL rmr_next_rvalid got %b exp 01", bus_a.m_rvalid);
    end
    tick();
  endtask

  task automatic test_lock;
`ifdef ARB_LOCK_EN
    logic [1:0] exp_g [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    logic [1:0] exp_g [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.m_req = 2'b11;
    for (int i = 0; i < 9; i++) begin
      bus_a.m_lock = (i < 8) ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (bus_a.m_gnt !== exp_g[i]) begin
        errors++; $display("FAIL lock_gnt cyc %0d got %b exp %b", i, bus_a.m_gnt, exp_g[i]);
      end
      tick();
    end
    bus_a.m_req = 2'b00;
    bus_a.m_lock = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rst_b = 1'b1;
    bus_a.m_req = '0; bus_a.m_we = '0; bus_a.m_be = '0; bus_a.m_addr = '0;
    bus_a.m_wdata = '0; bus_a.m_lock = '0; bus_a.s_rdata = '0;
    bus_b.m_req = '0; bus_b.m_we = '0; bus_b.m_be = '0; bus_b.m_addr = '0;
    bus_b.m_wdata = '0; bus_b.m_lock = '0; bus_b.s_rdata = '0;
    test_reset();
    test_round_robin();
    test_max_burst_one();
    test_sole_requester();
    test_write();
    test_reset_mid_read();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
